// File: rtl/date_string_emitter.sv
// date_string_emitter: serialises a binary date as ASCII "YYYY<s>M[M]<s>D[D]" under valid/ready
// Flow: IDLE -> CONV (14-cycle double-dabble of the year) -> CHECK (date validation) -> EMIT or err pulse.
// Ports: clk, reset (async, active-high); start_i, year_i[13:0], month_i[3:0], day_i[4:0],
//   sep_sel_i[1:0] (00 '-', 01 '/', 10 '.', 11 DEFAULT_SEP), out_ready_i;
//   out_o[7:0] (00 when idle), out_valid_o, busy_o, done_o (pulse), err_o (pulse).
// Build option: define ZERO_PAD_EN to always emit two-digit month and day.
module date_string_emitter #(
  parameter int unsigned MIN_YEAR = 1000,
  parameter int unsigned MAX_YEAR = 9999,
  parameter logic [7:0] DEFAULT_SEP = 8'h2D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [13:0] year_i,
  input  logic [3:0]  month_i,
  input  logic [4:0]  day_i,
  input  logic [1:0]  sep_sel_i,
  input  logic        out_ready_i,
  output logic [7:0]  out_o,
  output logic        out_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, CONV, CHECK, EMIT} state_t;
  localparam logic [13:0] MIN_Y = 14'(MIN_YEAR);
  localparam logic [13:0] MAX_Y = 14'(MAX_YEAR);
  state_t state_q, state_d;
  logic [13:0] year_q, year_d;
  logic [3:0] month_q, month_d;
  logic [4:0] day_q, day_d;
  logic [1:0] sep_q, sep_d;
  logic [29:0] dd_q, dd_d;
  logic [3:0] cnt_q, cnt_d, idx_q, idx_d;
  logic done_q, done_d, err_q, err_d;
  logic [15:0] adj, bcd;
  logic [1:0] cm;
  logic leap, bad, mt_en, dt_en;
  logic [4:0] dim, dsub;
  logic [3:0] mt, mu, dt, du, digit, nxt;
  logic [7:0] sep_c, chr;
  // Each BCD digit >= 5 gets +3 before the shift so it carries correctly into the next digit.
  for (genvar d = 0; d < 4; d++) begin : g_adj
    assign adj[4*d+:4] = dd_q[14+4*d+:4] + (dd_q[14+4*d+:4] >= 4'd5 ? 4'd3 : 4'd0);
  end
  assign bcd = dd_q[29:14];
  // Century years: (10*Y3+Y2) mod 4 equals (2*Y3+Y2) mod 4, so only low bits matter.
  assign cm = {bcd[12], 1'b0} + bcd[9:8];
  assign leap = (bcd[7:0] != 8'd0) ? (year_q[1:0] == 2'd0) : (cm == 2'd0);
  assign dim = (month_q == 4'd2) ? (leap ? 5'd29 : 5'd28) :
               (month_q == 4'd4 || month_q == 4'd6 || month_q == 4'd9 || month_q == 4'd11) ? 5'd30 : 5'd31;
  assign bad = year_q < MIN_Y || year_q > MAX_Y || month_q == 4'd0 || month_q > 4'd12 ||
               day_q == 5'd0 || day_q > dim;
  assign mt = (month_q >= 4'd10) ? 4'd1 : 4'd0;
  assign mu = (month_q >= 4'd10) ? month_q - 4'd10 : month_q;
  assign dt = (day_q >= 5'd30) ? 4'd3 : (day_q >= 5'd20) ? 4'd2 : (day_q >= 5'd10) ? 4'd1 : 4'd0;
  assign dsub = day_q - {1'b0, dt} * 5'd10;
  assign du = dsub[3:0];
`ifdef ZERO_PAD_EN
  assign mt_en = 1'b1;
  assign dt_en = 1'b1;
`else
  assign mt_en = month_q >= 4'd10;
  assign dt_en = day_q >= 5'd10;
`endif
  assign sep_c = (sep_q == 2'b00) ? 8'h2D : (sep_q == 2'b01) ? 8'h2F : (sep_q == 2'b10) ? 8'h2E : DEFAULT_SEP;
  // Character slots: 0-3 year, 4 sep, 5-6 month, 7 sep, 8-9 day; absent tens digits are skipped.
  always_comb begin
    digit = 4'd0;
    case (idx_q)
      4'd0: digit = bcd[15:12];
      4'd1: digit = bcd[11:8];
      4'd2: digit = bcd[7:4];
      4'd3: digit = bcd[3:0];
      4'd5: digit = mt;
      4'd6: digit = mu;
      4'd8: digit = dt;
      4'd9: digit = du;
      default: digit = 4'd0;
    endcase
  end
  assign chr = (idx_q == 4'd4 || idx_q == 4'd7) ? sep_c : {4'h3, digit};
  assign nxt = (idx_q == 4'd4 && !mt_en) ? 4'd6 : (idx_q == 4'd7 && !dt_en) ? 4'd9 : idx_q + 4'd1;
  always_comb begin
    state_d = state_q;
    year_d = year_q;
    month_d = month_q;
    day_d = day_q;
    sep_d = sep_q;
    dd_d = dd_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        year_d = year_i;
        month_d = month_i;
        day_d = day_i;
        sep_d = sep_sel_i;
        dd_d = {16'd0, year_i};
        cnt_d = 4'd0;
        state_d = CONV;
      end
      CONV: begin
        dd_d = {adj[14:0], dd_q[13:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd13) ? CHECK : CONV;
      end
      CHECK: begin
        err_d = bad;
        idx_d = 4'd0;
        state_d = bad ? IDLE : EMIT;
      end
      EMIT: if (out_ready_i) begin
        done_d = idx_q == 4'd9;
        idx_d = nxt;
        state_d = (idx_q == 4'd9) ? IDLE : EMIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      year_q <= '0;
      month_q <= '0;
      day_q <= '0;
      sep_q <= '0;
      dd_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      year_q <= year_d;
      month_q <= month_d;
      day_q <= day_d;
      sep_q <= sep_d;
      dd_q <= dd_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign out_valid_o = state_q == EMIT;
  assign out_o = out_valid_o ? chr : 8'h00;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_date_string_emitter.sv
// tb_date_string_emitter: directed checks of date_string_emitter strings, latency, errors, stalls and reset
module tb_date_string_emitter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_i = 1'b0;
  logic [13:0] year_i = '0;
  logic [3:0] month_i = '0;
  logic [4:0] day_i = '0;
  logic [1:0] sep_sel_i = '0;
  logic out_ready_i = 1'b1;
  logic [7:0] out_o;
  logic out_valid_o, busy_o, done_o, err_o;
  int n_cmp = 0;
  int n_err = 0;
  date_string_emitter #(.DEFAULT_SEP(8'h5F)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .year_i(year_i), .month_i(month_i),
    .day_i(day_i), .sep_sel_i(sep_sel_i), .out_ready_i(out_ready_i), .out_o(out_o),
    .out_valid_o(out_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Leaves the bench at the negedge of cycle 16 (cycle 0 presents start).
  task automatic start_date(input int y, input int m, input int d, input int s);
    year_i = 14'(y);
    month_i = 4'(m);
    day_i = 5'(d);
    sep_sel_i = 2'(s);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    year_i = 14'd5555;
    month_i = 4'd7;
    day_i = 5'd7;
    sep_sel_i = 2'b10;
    chk("busy_after_start", busy_o, 1);
    repeat (14) @(negedge clk);
    chk("cycle15_quiet", {out_valid_o, err_o, done_o, busy_o}, 4'b0001);
    @(negedge clk);
  endtask
  task automatic expect_str(input string s, input bit toggle, input bit poke);
    int got = 0;
    int cyc = 0;
    logic [7:0] held = 8'h00;
    bit stall = 1'b0;
    while (got < s.len() && cyc < 100) begin
      out_ready_i = toggle ? (cyc % 3 == 0) : 1'b1;
      start_i = poke && cyc == 3;
      if (poke && cyc == 3) begin
        year_i = 14'd1234;
        month_i = 4'd1;
        day_i = 5'd1;
        sep_sel_i = 2'b01;
      end
      if (stall) chk("stall_hold", out_o, held);
      chk($sformatf("char%0d", got), {out_valid_o, out_o}, {1'b1, s[got]});
      held = out_o;
      stall = !out_ready_i;
      if (out_ready_i) got++;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    out_ready_i = 1'b1;
    chk("all_chars_accepted", got, s.len());
    chk("done_cycle", {done_o, err_o, out_valid_o, busy_o}, 4'b1000);
    @(negedge clk);
    chk("done_clear", {done_o, busy_o}, 2'b00);
  endtask
  task automatic expect_err(input string tag);
    chk(tag, {err_o, done_o, out_valid_o, busy_o}, 4'b1000);
    @(negedge clk);
    chk({tag, "_clear"}, {err_o, out_valid_o}, 2'b00);
  endtask
  initial begin
    string s_leap, s_stall, s_rst;
`ifdef ZERO_PAD_EN
    s_leap = "2000/02/29";
    s_stall = "1999.09.09";
    s_rst = "2024-12-01";
`else
    s_leap = "2000/2/29";
    s_stall = "1999.9.9";
    s_rst = "2024-12-1";
`endif
    repeat (2) @(negedge clk);
    chk("reset_outputs", {out_o, out_valid_o, busy_o, done_o, err_o}, 12'h000);
    reset = 1'b0;
    @(negedge clk);
    start_date(2021, 10, 24, 0);
    expect_str("2021-10-24", 1'b0, 1'b0);
    start_date(2000, 2, 29, 1);
    expect_str(s_leap, 1'b0, 1'b0);
    start_date(1900, 2, 29, 0);
    expect_err("err_1900_feb29");
    start_date(2023, 4, 31, 0);
    expect_err("err_apr31");
    start_date(999, 1, 1, 0);
    expect_err("err_year_low");
    start_date(2021, 13, 1, 0);
    expect_err("err_month13");
    start_date(10000, 1, 1, 0);
    expect_err("err_year_high");
    start_date(2021, 1, 0, 0);
    expect_err("err_day0");
    start_date(1999, 9, 9, 2);
    expect_str(s_stall, 1'b1, 1'b0);
    start_date(9999, 12, 31, 0);
    expect_str("9999-12-31", 1'b0, 1'b1);
    start_date(2023, 12, 31, 3);
    expect_str("2023_12_31", 1'b0, 1'b0);
    start_date(2021, 10, 24, 0);
    repeat (3) @(negedge clk);
    chk("pre_reset_char4", out_o, 8'h31);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {out_o, out_valid_o, busy_o, done_o, err_o}, 12'h000);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_reset", {done_o, err_o, busy_o, out_valid_o}, 4'b0000);
    end
    start_date(2024, 12, 1, 0);
    expect_str(s_rst, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
